lift_scheduler: RTL and testbench

//  Request scheduler for the single-car 7-floor lift. Latches cab and hall calls, owns the door timer,
//  and drives currentDirection/doorState into the Lift mover (consumes its nextFloor/move).

---
 rtl/lift_scheduler.sv | 95 +++++++++
 tb/tb_lift_scheduler.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/lift_scheduler.sv
// lift_scheduler: SCAN request scheduler for a single-car 7-floor lift
// Ports: clk, reset (async, active-low); cabReq/hallUpReq/hallDownReq request pulses (bit i = floor i+1);
//   liftFloor/liftMove from the Lift mover; currentDirection (UP=10, DOWN=01, STOP=00) and doorState to it;
//   cabLamp/upLamp/downLamp show pending calls.
module lift_scheduler #(
   parameter int DOOR_CYCLES = 10000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] cabReq,
   input  logic [6:0] hallUpReq,
   input  logic [6:0] hallDownReq,
   input  logic [2:0] liftFloor,
   input  logic       liftMove,
   output logic [1:0] currentDirection,
   output logic       doorState,
   output logic [6:0] cabLamp,
   output logic [6:0] upLamp,
   output logic [6:0] downLamp
);
   localparam int CW = $clog2(DOOR_CYCLES + 1);
   localparam logic [CW-1:0] LOAD = CW'(DOOR_CYCLES - 1);
   typedef enum logic [1:0] {IDLE, DOOR, UP_RUN, DOWN_RUN} state_t;
   state_t state, nxt;
   logic [CW-1:0] cnt, cnt_n;
   logic last_up, last_up_n, move_d;
   logic valid, above, below, dir_up, ahead, hit, req_hit, arrive, run, stop_floor;
   logic [6:0] f_m, ab_m, be_m, all_l, up_in, dn_in, srv_c, srv_u, srv_d;
   assign valid = liftFloor != 3'd0;
   assign up_in = hallUpReq & 7'h3f;
   assign dn_in = hallDownReq & 7'h7e;
   assign all_l = cabLamp | upLamp | downLamp;
   always_comb begin
      for (int i = 0; i < 7; i++) begin
         f_m[i]  = liftFloor == 3'(i + 1);
         ab_m[i] = valid && 3'(i + 1) > liftFloor;
         be_m[i] = valid && 3'(i + 1) < liftFloor;
      end
   end
   assign above = |(all_l & ab_m);
   assign below = |(all_l & be_m);
   assign dir_up = state == UP_RUN || (state != DOWN_RUN && last_up);
   assign ahead = dir_up ? above : below;
   // Calls at this floor served by a stop: the cab call, the hall call in the travel
   // direction, and the opposite hall call only when nothing lies ahead (car reverses).
   // The same mask swallows new pulses while the door is open, so nothing served is lost.
   assign srv_c = f_m;
   assign srv_u = (dir_up || !ahead) ? f_m : 7'd0;
   assign srv_d = (!dir_up || !ahead) ? f_m : 7'd0;
   assign hit = |((cabLamp & srv_c) | (upLamp & srv_u) | (downLamp & srv_d));
   assign req_hit = |((cabReq & srv_c) | (up_in & srv_u) | (dn_in & srv_d));
   assign arrive = move_d && !liftMove;
   assign run = state == UP_RUN || state == DOWN_RUN;
   assign stop_floor = liftFloor == (state == UP_RUN ? 3'd7 : 3'd1);
   always_comb begin
      nxt = state;
      cnt_n = cnt;
      if (state == DOOR) begin
         cnt_n = req_hit ? LOAD : cnt - CW'(1);
         nxt = (!req_hit && cnt == '0) ? IDLE : DOOR;
      end else if (!liftMove && state == IDLE) begin
         nxt = hit ? DOOR : (above && (last_up || !below)) ? UP_RUN : below ? DOWN_RUN : IDLE;
      end else if (run && arrive) begin
         nxt = !valid ? IDLE : (hit || stop_floor) ? DOOR : state;
      end
      if (nxt == DOOR && state != DOOR) cnt_n = LOAD;
   end
   // Direction memory flips only when a run stops with no calls left ahead.
   assign last_up_n = nxt == UP_RUN ? 1'b1 : nxt == DOWN_RUN ? 1'b0 :
                      (run && nxt == DOOR && !ahead) ? !dir_up : last_up;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt <= '0;
         last_up <= 1'b1;
         move_d <= 1'b0;
         cabLamp <= '0;
         upLamp <= '0;
         downLamp <= '0;
         doorState <= 1'b0;
         currentDirection <= 2'b00;
      end else begin
         state <= nxt;
         cnt <= cnt_n;
         last_up <= last_up_n;
         move_d <= liftMove;
         cabLamp <= (cabLamp | cabReq) & ~(nxt == DOOR ? srv_c : 7'd0);
         upLamp <= (upLamp | up_in) & ~(nxt == DOOR ? srv_u : 7'd0);
         downLamp <= (downLamp | dn_in) & ~(nxt == DOOR ? srv_d : 7'd0);
         doorState <= state == DOOR;
         currentDirection <= {state == UP_RUN && valid && liftFloor != 3'd7,
                              state == DOWN_RUN && valid && liftFloor != 3'd1};
      end
   end
endmodule

// File: tb/tb_lift_scheduler.sv
// tb_lift_scheduler: directed bench for lift_scheduler with a short door time
module tb_lift_scheduler;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [6:0] cabReq = '0, hallUpReq = '0, hallDownReq = '0;
   logic [2:0] liftFloor = 3'd1;
   logic liftMove = 1'b0;
   logic [1:0] currentDirection;
   logic doorState;
   logic [6:0] cabLamp, upLamp, downLamp;
   int checks = 0, errors = 0, n;

   lift_scheduler #(.DOOR_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .cabReq(cabReq), .hallUpReq(hallUpReq), .hallDownReq(hallDownReq),
      .liftFloor(liftFloor), .liftMove(liftMove), .currentDirection(currentDirection),
      .doorState(doorState), .cabLamp(cabLamp), .upLamp(upLamp), .downLamp(downLamp)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic pulse(input logic [6:0] c, input logic [6:0] u, input logic [6:0] d);
      cabReq = c;
      hallUpReq = u;
      hallDownReq = d;
      tick;
      cabReq = '0;
      hallUpReq = '0;
      hallDownReq = '0;
   endtask

   task automatic move(input logic [2:0] f);
      liftMove = 1'b1;
      liftFloor = f;
      tick;
      liftMove = 1'b0;
      tick;
   endtask

   task automatic door_len(output int k);
      k = 0;
      while (doorState && k < 40) begin
         k++;
         tick;
      end
   endtask

   initial begin
      #2 reset = 1'b0;
      #2;
      chk("rst_cab", cabLamp, 7'h00);
      chk("rst_dir", currentDirection, 2'b00);
      chk("rst_door", doorState, 1'b0);
      tick;
      reset = 1'b1;
      tick;
      // floor 1 -> cab call floor 5
      pulse(7'h10, 7'h00, 7'h00);
      chk("t2_lamp", cabLamp, 7'h10);
      chk("t2_dir0", currentDirection, 2'b00);
      tick;
      chk("t2_dir1", currentDirection, 2'b00);
      tick;
      chk("t2_up", currentDirection, 2'b10);
      move(3'd2);
      chk("t2_pass2", currentDirection, 2'b10);
      move(3'd3);
      move(3'd4);
      chk("t2_pass4", currentDirection, 2'b10);
      chk("t2_nodoor", doorState, 1'b0);
      move(3'd5);
      chk("t2_clr", cabLamp, 7'h00);
      tick;
      chk("t2_open", doorState, 1'b1);
      chk("t2_stop", currentDirection, 2'b00);
      door_len(n);
      chk("t2_doorlen", n, 4);
      // floor 3, only hall-down at floor 6
      liftFloor = 3'd3;
      pulse(7'h00, 7'h00, 7'h20);
      chk("t3_lamp", downLamp, 7'h20);
      tick;
      tick;
      chk("t3_up", currentDirection, 2'b10);
      pulse(7'h02, 7'h00, 7'h00);
      move(3'd4);
      chk("t3_pass4", currentDirection, 2'b10);
      move(3'd5);
      chk("t3_pass5", doorState, 1'b0);
      move(3'd6);
      chk("t3_clr", downLamp, 7'h00);
      chk("t3_cab", cabLamp, 7'h02);
      tick;
      chk("t3_open", doorState, 1'b1);
      door_len(n);
      chk("t3_doorlen", n, 4);
      tick;
      chk("t3_down", currentDirection, 2'b01);
      // stop at floor 4 on the way down, then re-press floor 4 while open
      pulse(7'h08, 7'h00, 7'h00);
      move(3'd5);
      chk("t4_pass5", currentDirection, 2'b01);
      move(3'd4);
      chk("t4_clr", cabLamp, 7'h02);
      tick;
      chk("t4_open", doorState, 1'b1);
      tick;
      pulse(7'h08, 7'h00, 7'h00);
      chk("t4_nolatch", cabLamp, 7'h02);
      tick;
      tick;
      tick;
      chk("t4_held", doorState, 1'b1);
      pulse(7'h40, 7'h00, 7'h08);
      chk("t4_reopen", doorState, 1'b1);
      chk("t4_hall", downLamp, 7'h00);
      chk("t4_cab7", cabLamp, 7'h42);
      door_len(n);
      chk("t4_doorlen", n, 5);
      // idle at 4, lastDir DOWN, calls at 2 and 7
      tick;
      chk("t5_down", currentDirection, 2'b01);
      move(3'd3);
      chk("t5_pass3", currentDirection, 2'b01);
      move(3'd2);
      chk("t5_clr2", cabLamp, 7'h40);
      tick;
      chk("t5_open2", doorState, 1'b1);
      door_len(n);
      chk("t5_doorlen", n, 4);
      tick;
      chk("t5_up", currentDirection, 2'b10);
      move(3'd3);
      move(3'd4);
      move(3'd5);
      move(3'd6);
      chk("t5_pass6", currentDirection, 2'b10);
      liftMove = 1'b1;
      liftFloor = 3'd7;
      tick;
      chk("t6_noup7", currentDirection, 2'b00);
      liftMove = 1'b0;
      tick;
      chk("t5_clr7", cabLamp, 7'h00);
      tick;
      chk("t5_open7", doorState, 1'b1);
      door_len(n);
      chk("t5_doorlen7", n, 4);
      // invalid floor keeps calls and stays stopped
      liftFloor = 3'd0;
      pulse(7'h01, 7'h40, 7'h01);
      chk("t6_keep", cabLamp, 7'h01);
      chk("t6_up7ign", upLamp, 7'h00);
      chk("t6_dn1ign", downLamp, 7'h00);
      tick;
      tick;
      tick;
      chk("t6_f0dir", currentDirection, 2'b00);
      chk("t6_f0door", doorState, 1'b0);
      chk("t6_f0keep", cabLamp, 7'h01);
      liftFloor = 3'd3;
      tick;
      tick;
      chk("t6_down", currentDirection, 2'b01);
      move(3'd2);
      chk("t6_pass2", currentDirection, 2'b01);
      liftMove = 1'b1;
      liftFloor = 3'd1;
      tick;
      chk("t6_nodown1", currentDirection, 2'b00);
      liftMove = 1'b0;
      tick;
      chk("t6_clr1", cabLamp, 7'h00);
      tick;
      chk("t6_open1", doorState, 1'b1);
      door_len(n);
      chk("t6_doorlen", n, 4);
      // reset in the middle of an up run
      pulse(7'h48, 7'h00, 7'h00);
      tick;
      tick;
      chk("t1_up", currentDirection, 2'b10);
      chk("t1_lamps", cabLamp, 7'h48);
      liftMove = 1'b1;
      liftFloor = 3'd2;
      tick;
      reset = 1'b0;
      #1;
      chk("t1_cab0", cabLamp, 7'h00);
      chk("t1_dir0", currentDirection, 2'b00);
      chk("t1_door0", doorState, 1'b0);
      liftMove = 1'b0;
      tick;
      tick;
      reset = 1'b1;
      tick;
      tick;
      tick;
      chk("t1_hold_cab", cabLamp, 7'h00);
      chk("t1_hold_dir", currentDirection, 2'b00);
      chk("t1_hold_door", doorState, 1'b0);
      chk("t1_hold_hall", {upLamp, downLamp}, 14'h0000);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
